lcm: RTL and testbench

Sequential least-common-multiple stage that sits directly downstream of the `gcd` datapath. It consumes the operand pair `a`, `b` together with their greatest common divisor `g` produced by `gcd`, and computes `lcm = (a / g) * b`. It uses a multi-cycle restoring divider followed by a multi-cycle shift-add multiplier, with no hardware divider or multiplier. A single-cycle `done` pulse marks the result, and `return_val` holds it until the next completion.

---
 rtl/lcm_if.sv | 38 +++
 rtl/lcm.sv | 163 ++++++++++++++++
 tb/tb_lcm.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lcm_if.sv
// -----------------------------------------------------------------------------
// lcm_if : request/result bundle between a producer (gcd stage or bench) and
//          the lcm stage.
//
//   a, b        operand pair, same values fed to the upstream gcd
//   g           gcd(a, b) as produced upstream
//   g_valid     start request; a, b, g valid this cycle
//   ready       lcm stage is idle and will accept a request
//   done        one-cycle completion pulse
//   return_val  low WIDTH bits of the lcm, held until the next completion
//   overflow    true product did not fit in WIDTH bits
//   div_err     g was zero at acceptance
//
// master drives the request side, slave (the lcm stage) drives the results.
// -----------------------------------------------------------------------------
interface lcm_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    logic             g_valid;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] return_val;
    logic             overflow;
    logic             div_err;

    modport master (
        output a, b, g, g_valid,
        input  ready, done, return_val, overflow, div_err
    );

    modport slave (
        input  a, b, g, g_valid,
        output ready, done, return_val, overflow, div_err
    );
endinterface

// File: rtl/lcm.sv
// -----------------------------------------------------------------------------
// lcm : sequential least-common-multiple stage, lcm = (a / g) * b.
//
// Ports
//   sys_clk     rising-edge clock
//   sys_rst_n   asynchronous active-low reset
//   bus         lcm_if.slave: a, b, g, g_valid in; ready, done, return_val,
//               overflow, div_err out
//
// Flow: IDLE -> DIV (WIDTH cycles, restoring divide a/g, MSB first)
//            -> MUL (WIDTH cycles, shift-add q*b, LSB first) -> DONE -> IDLE.
// A zero g skips straight from IDLE to DONE with div_err set.
// All outputs are registered. Result fields and the done pulse are loaded on
// the edge that enters DONE, so they become visible together.
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module lcm #(
    parameter int WIDTH = 32
) (
    input  logic   sys_clk,
    input  logic   sys_rst_n,
    lcm_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_DIV  = 4'b0010,
        S_MUL  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     a_reg;       // dividend, shifts into quotient in DIV
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     g_reg;
    logic [WIDTH:0]       rem_reg;
    logic [WIDTH-1:0]     mplier_reg;  // quotient, consumed LSB first
    logic [2*WIDTH-1:0]   mcand_reg;   // b, shifted left once per MUL cycle
    logic [2*WIDTH-1:0]   prod_reg;
    logic [CW-1:0]        cnt_reg;

    logic                 ready_reg;
    logic                 done_reg;
    logic [WIDTH-1:0]     ret_reg;
    logic                 ovf_reg;
    logic                 derr_reg;

    // Divider step. The extra top bit of rem_wide/rem_sub acts as the borrow:
    // a clear sign bit after subtracting g means the quotient bit is 1.
    logic [WIDTH+1:0]     rem_wide;
    logic [WIDTH+1:0]     rem_sub;
    logic                 q_bit;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     quot_next;

    // Multiplier step
    logic [2*WIDTH-1:0]   mcand_gated;
    logic [2*WIDTH-1:0]   prod_next;
    logic                 last_cycle;

    always_comb begin
        rem_wide  = {rem_reg, a_reg[WIDTH-1]};
        rem_sub   = rem_wide - {2'b00, g_reg};
        q_bit     = ~rem_sub[WIDTH+1];
        rem_next  = q_bit ? rem_sub[WIDTH:0] : rem_wide[WIDTH:0];
        quot_next = {a_reg[WIDTH-2:0], q_bit};
    end

    // Partial product: multiplicand masked by the current multiplier bit.
    genvar gi;
    generate
        for (gi = 0; gi < 2*WIDTH; gi++) begin : g_pp
            assign mcand_gated[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign prod_next  = prod_reg + mcand_gated;
    assign last_cycle = (cnt_reg == CW'(WIDTH-1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg  <= S_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            g_reg      <= '0;
            rem_reg    <= '0;
            mplier_reg <= '0;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            ret_reg    <= '0;
            ovf_reg    <= 1'b0;
            derr_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.g_valid) begin
                        a_reg      <= bus.a;
                        b_reg      <= bus.b;
                        g_reg      <= bus.g;
                        rem_reg    <= '0;
                        mplier_reg <= '0;
                        mcand_reg  <= '0;
                        prod_reg   <= '0;
                        cnt_reg    <= '0;
                        ready_reg  <= 1'b0;
                        if (bus.g == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                            ret_reg   <= '0;
                            ovf_reg   <= 1'b0;
                            derr_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    a_reg   <= quot_next;
                    rem_reg <= rem_next;
                    cnt_reg <= last_cycle ? '0 : cnt_reg + 1'b1;
                    if (last_cycle) begin
                        // Remainder is dropped; it is zero when g is a true gcd.
                        mplier_reg <= quot_next;
                        mcand_reg  <= {{WIDTH{1'b0}}, b_reg};
                        state_reg  <= S_MUL;
                    end
                end
                S_MUL: begin
                    prod_reg   <= prod_next;
                    mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                    mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                    cnt_reg    <= last_cycle ? '0 : cnt_reg + 1'b1;
                    if (last_cycle) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                        ret_reg   <= prod_next[WIDTH-1:0];
                        ovf_reg   <= |prod_next[2*WIDTH-1:WIDTH];
                        derr_reg  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready      = ready_reg;
    assign bus.done       = done_reg;
    assign bus.return_val = ret_reg;
    assign bus.overflow   = ovf_reg;
    assign bus.div_err    = derr_reg;
endmodule

// File: tb/tb_lcm.sv
// -----------------------------------------------------------------------------
// tb_lcm : self-checking bench for lcm (WIDTH = 32).
// Table of directed vectors, hand-written busy/reset sequences, then random
// requests checked against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_lcm;
    localparam int W = 32;

    logic sys_clk;
    logic sys_rst_n;
    int   tests;
    int   failed;

    lcm_if #(.WIDTH(W)) bus ();

    lcm #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] g;
        logic [31:0] exp_ret;
        logic        exp_ovf;
        logic        exp_derr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: lcm = floor(a/g) * b over full precision, zero g flagged.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g,
                         output logic [31:0] ret, output logic ovf, output logic derr,
                         output int lat);
        logic [63:0] p;
        if (g == 0) begin
            ret = 0; ovf = 0; derr = 1; lat = 1;
        end else begin
            p    = 64'(a / g) * 64'(b);
            ret  = p[31:0];
            ovf  = (p[63:32] != 0);
            derr = 0;
            lat  = 2 * W + 1;
        end
    endtask

    function automatic logic [31:0] gcd_of(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // Present a request for one cycle; returns at the negedge of cycle E0+1.
    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
        @(negedge sys_clk);
        check("ready_before_accept", 64'(bus.ready), 64'd1);
        bus.a = a; bus.b = b; bus.g = g; bus.g_valid = 1'b1;
        @(negedge sys_clk);
        bus.g_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.g = $urandom;
    endtask

    task automatic run_req(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] g, input logic [31:0] er, input logic eo,
                           input logic ed, input int el);
        int lat;
        bit busy_ok;
        start_req(a, b, g);
        lat = 1;
        busy_ok = 1;
        while (!bus.done && lat < 200) begin
            if (bus.ready) busy_ok = 0;
            @(negedge sys_clk);
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(el));
        check({name, "_return_val"}, 64'(bus.return_val), 64'(er));
        check({name, "_overflow"}, 64'(bus.overflow), 64'(eo));
        check({name, "_div_err"}, 64'(bus.div_err), 64'(ed));
        check({name, "_ready_low_busy"}, 64'(busy_ok && !bus.ready), 64'd1);
        @(negedge sys_clk);
        check({name, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({name, "_ready_back"}, 64'(bus.ready), 64'd1);
        check({name, "_hold"}, 64'(bus.return_val), 64'(er));
        $display("[TB] %s a=%0h b=%0h g=%0h -> ret=%0h ovf=%0d derr=%0d lat=%0d",
                 name, a, b, g, bus.return_val, bus.overflow, bus.div_err, lat);
    endtask

    initial begin
        logic [31:0] ra, rb, rg, er;
        logic        eo, ed;
        int          el;
        int          done_cnt;
        int          done_lat;
        int          lat;
        bit          busy_ok;

        tests = 0;
        failed = 0;
        bus.a = 0; bus.b = 0; bus.g = 0; bus.g_valid = 0;

        vecs[0]  = '{"basic",      32'd12, 32'd18, 32'd6, 32'd36, 1'b0, 1'b0, 65};
        vecs[1]  = '{"zero_a",     32'd0,  32'd5,  32'd5, 32'd0,  1'b0, 1'b0, 65};
        vecs[2]  = '{"zero_g",     32'd0,  32'd0,  32'd0, 32'd0,  1'b0, 1'b1, 1};
        vecs[3]  = '{"after_err",  32'd4,  32'd6,  32'd2, 32'd12, 1'b0, 1'b0, 65};
        vecs[4]  = '{"overflow",   32'h00010000, 32'h00010001, 32'd1, 32'h00010000, 1'b1, 1'b0, 65};
        vecs[5]  = '{"seven",      32'd7,  32'd21, 32'd7, 32'd21, 1'b0, 1'b0, 65};
        vecs[6]  = '{"zero_b",     32'd5,  32'd0,  32'd5, 32'd0,  1'b0, 1'b0, 65};
        vecs[7]  = '{"all_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 65};
        vecs[8]  = '{"max_times1", 32'hFFFFFFFF, 32'd1, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 65};
        vecs[9]  = '{"max_times2", 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 1'b1, 1'b0, 65};
        vecs[10] = '{"g0_nonzero", 32'd3,  32'd5,  32'd0, 32'd0,  1'b0, 1'b1, 1};
        vecs[11] = '{"coprime",    32'd9,  32'd10, 32'd1, 32'd90, 1'b0, 1'b0, 65};

        // Reset state
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_ret", 64'(bus.return_val), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        check("rst_derr", 64'(bus.div_err), 64'd0);
        sys_rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++)
            run_req(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].g,
                    vecs[i].exp_ret, vecs[i].exp_ovf, vecs[i].exp_derr, vecs[i].exp_lat);

        // Busy: second request 10 cycles in is ignored
        start_req(32'd12, 32'd18, 32'd6);
        lat = 1; done_cnt = 0; done_lat = 0; busy_ok = 1;
        while (lat < 72) begin
            if (lat == 10) begin
                bus.a = 32'd3; bus.b = 32'd5; bus.g = 32'd1; bus.g_valid = 1'b1;
            end else begin
                bus.g_valid = 1'b0;
            end
            if (bus.done) begin done_cnt++; done_lat = lat; end
            if (lat <= 65 && bus.ready) busy_ok = 0;
            @(negedge sys_clk);
            lat++;
        end
        check("busy_done_count", 64'(done_cnt), 64'd1);
        check("busy_done_lat", 64'(done_lat), 64'd65);
        check("busy_ret", 64'(bus.return_val), 64'd36);
        check("busy_ready_low", 64'(busy_ok), 64'd1);
        $display("[TB] busy sequence: dones=%0d at lat=%0d ret=%0h", done_cnt, done_lat, bus.return_val);
        run_req("busy_retry", 32'd3, 32'd5, 32'd1, 32'd15, 1'b0, 1'b0, 65);

        // Reset mid-MUL
        start_req(32'd12, 32'd18, 32'd6);
        lat = 1; done_cnt = 0;
        while (lat < 40) begin
            if (bus.done) done_cnt++;
            @(negedge sys_clk);
            lat++;
        end
        sys_rst_n = 1'b0;
        #1;
        check("midrst_ret", 64'(bus.return_val), 64'd0);
        check("midrst_ready", 64'(bus.ready), 64'd1);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_ovf", 64'(bus.overflow), 64'd0);
        check("midrst_derr", 64'(bus.div_err), 64'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 70; k++) begin
            if (bus.done) done_cnt++;
            @(negedge sys_clk);
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        $display("[TB] reset mid-MUL: dones after abort=%0d", done_cnt);
        run_req("after_reset", 32'd7, 32'd21, 32'd7, 32'd21, 1'b0, 1'b0, 65);

        // Random requests against the reference model
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom_range(0, 1000); rb = $urandom_range(0, 1000); end
                1: begin ra = $urandom; rb = $urandom_range(0, 65535); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            rg = gcd_of(ra, rb);
            if (i % 7 == 6) rg = $urandom_range(1, 255);
            if (i % 9 == 8) rg = 0;
            model(ra, rb, rg, er, eo, ed, el);
            run_req($sformatf("rand%0d", i), ra, rb, rg, er, eo, ed, el);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
